// File: rtl/riscv_commit_checker_if.sv
`default_nettype none
// ============================================================================
// riscv_commit_checker_if : table-config and retire-side bus of the commit checker
// Revision 1.0
// ============================================================================
interface riscv_commit_checker_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
);
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [2:0]       cfg_mode;
    logic [XLEN-1:0]  cfg_pc;
    logic [XLEN-1:0]  cfg_exp_a;
    logic [XLEN-1:0]  cfg_exp_d;
    logic [XLEN-1:0]  end_pc;
    logic             start;
    logic             ret_valid;
    logic [XLEN-1:0]  ret_pc;
    logic [XLEN-1:0]  ret_result;
    logic [XLEN-1:0]  ret_dataadr;
    logic [XLEN-1:0]  ret_wdata;
    logic             ret_memwrite;

    modport master (
        output cfg_we, cfg_idx, cfg_mode, cfg_pc, cfg_exp_a, cfg_exp_d, end_pc, start,
               ret_valid, ret_pc, ret_result, ret_dataadr, ret_wdata, ret_memwrite
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_mode, cfg_pc, cfg_exp_a, cfg_exp_d, end_pc, start,
               ret_valid, ret_pc, ret_result, ret_dataadr, ret_wdata, ret_memwrite
    );
endinterface
`default_nettype wire

// File: rtl/riscv_commit_checker.sv
`default_nettype none
// ============================================================================
// riscv_commit_checker : per-PC retire checker with pass/fail counters and abort
// Revision 1.0
// ============================================================================
module riscv_commit_checker #(
    parameter int  XLEN       = 32,
    parameter int  NUM_CHECKS = 32,
    parameter int  CNT_W      = 8,
    parameter int  TIMEOUT    = 4096,
    localparam int IDX_W      = $clog2(NUM_CHECKS)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    riscv_commit_checker_if.slave bus,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      pass_cnt_o,
    output logic [CNT_W-1:0]      fail_cnt_o,
    output logic                  first_fail_v_o,
    output logic [IDX_W-1:0]      first_fail_idx_o,
    output logic [1:0]            abort_cause_o
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2,
        S_ABORT   = 2'd3
    } state_e;

    localparam logic [2:0] M_OFF   = 3'd0;
    localparam logic [2:0] M_RES   = 3'd1;
    localparam logic [2:0] M_STORE = 3'd2;
    localparam logic [2:0] M_LOAD  = 3'd3;
    localparam logic [2:0] M_BOUND = 3'd4;

    localparam int             CYC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);

    state_e state_q, state_d;

    logic [2:0]      mode_q  [NUM_CHECKS];
    logic [XLEN-1:0] tpc_q   [NUM_CHECKS];
    logic [XLEN-1:0] exp_a_q [NUM_CHECKS];
    logic [XLEN-1:0] exp_d_q [NUM_CHECKS];

    logic            s1_v_q;
    logic [XLEN-1:0] s1_pc_q, s1_res_q, s1_adr_q, s1_wd_q;
    logic            s1_mw_q;

    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
    logic             ff_v_q;
    logic [IDX_W-1:0] ff_idx_q;
    logic [1:0]       abort_cause_q;
    logic [CYC_W-1:0] cyc_q;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             chk_pass, chk_fail, bound_viol;
    logic             end_hit, timeout;

    // Table is only writable while no run is in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                mode_q[i] <= M_OFF;
            end
        end else if (bus.cfg_we && (state_q != S_RUNNING) && (int'(bus.cfg_idx) < NUM_CHECKS)) begin
            mode_q[bus.cfg_idx]  <= bus.cfg_mode;
            tpc_q[bus.cfg_idx]   <= bus.cfg_pc;
            exp_a_q[bus.cfg_idx] <= bus.cfg_exp_a;
            exp_d_q[bus.cfg_idx] <= bus.cfg_exp_d;
        end
    end

    // Stage 1: a retirement is kept only if the run is still going next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q   <= 1'b0;
            s1_pc_q  <= '0;
            s1_res_q <= '0;
            s1_adr_q <= '0;
            s1_wd_q  <= '0;
            s1_mw_q  <= 1'b0;
        end else begin
            s1_v_q   <= bus.ret_valid && (state_q == S_RUNNING) && (state_d == S_RUNNING);
            s1_pc_q  <= bus.ret_pc;
            s1_res_q <= bus.ret_result;
            s1_adr_q <= bus.ret_dataadr;
            s1_wd_q  <= bus.ret_wdata;
            s1_mw_q  <= bus.ret_memwrite;
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (!hit && (mode_q[i] != M_OFF) && (mode_q[i] <= M_BOUND) && (tpc_q[i] == s1_pc_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        chk_pass   = 1'b0;
        chk_fail   = 1'b0;
        bound_viol = 1'b0;
        if (s1_v_q && hit) begin
            case (mode_q[hit_idx])
                M_RES: begin
                    chk_pass = (s1_res_q == exp_a_q[hit_idx]);
                    chk_fail = !chk_pass;
                end
                M_STORE: begin
                    chk_pass = s1_mw_q && (s1_adr_q == exp_a_q[hit_idx]) && (s1_wd_q == exp_d_q[hit_idx]);
                    chk_fail = !chk_pass;
                end
                M_LOAD: begin
                    chk_pass = (s1_adr_q == exp_a_q[hit_idx]) && (s1_res_q == exp_d_q[hit_idx]);
                    chk_fail = !chk_pass;
                end
                M_BOUND: begin
                    bound_viol = (s1_res_q > exp_a_q[hit_idx]);
                    chk_fail   = bound_viol;
                end
                default: ;
            endcase
        end
    end

    assign end_hit = s1_v_q && (s1_pc_q == bus.end_pc);
    assign timeout = (cyc_q == CYC_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks completion when the end_pc retirement also breaks a bound.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ABORT: begin
                if (bus.start) begin
                    state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (bound_viol || timeout) begin
                    state_d = S_ABORT;
                end else if (end_hit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            ff_v_q        <= 1'b0;
            ff_idx_q      <= '0;
            abort_cause_q <= 2'd0;
            cyc_q         <= '0;
        end else if ((state_q != S_RUNNING) && (state_d == S_RUNNING)) begin
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            ff_v_q        <= 1'b0;
            ff_idx_q      <= '0;
            abort_cause_q <= 2'd0;
            cyc_q         <= '0;
        end else if (state_q == S_RUNNING) begin
            cyc_q <= cyc_q + 1'b1;
            if (chk_pass && !(&pass_cnt_q)) begin
                pass_cnt_q <= pass_cnt_q + 1'b1;
            end
            if (chk_fail) begin
                if (!(&fail_cnt_q)) begin
                    fail_cnt_q <= fail_cnt_q + 1'b1;
                end
                if (!ff_v_q) begin
                    ff_v_q   <= 1'b1;
                    ff_idx_q <= hit_idx;
                end
            end
            if (state_d == S_ABORT) begin
                abort_cause_q <= bound_viol ? 2'd1 : 2'd2;
            end
        end
    end

    assign state_o          = state_q;
    assign pass_cnt_o       = pass_cnt_q;
    assign fail_cnt_o       = fail_cnt_q;
    assign first_fail_v_o   = ff_v_q;
    assign first_fail_idx_o = ff_idx_q;
    assign abort_cause_o    = abort_cause_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_commit_checker.sv
`default_nettype none
// ============================================================================
// tb_riscv_commit_checker : directed scenarios plus randomized runs vs a reference model
// Revision 1.0
// ============================================================================
module tb_riscv_commit_checker;
    localparam int XLEN       = 32;
    localparam int NUM_CHECKS = 8;
    localparam int CNT_W      = 3;
    localparam int TIMEOUT    = 16;
    localparam int IDX_W      = 3;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam logic [31:0] RAND_END = 32'h80;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_commit_checker_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus ();

    logic [1:0]       state;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic             ffv;
    logic [IDX_W-1:0] ffidx;
    logic [1:0]       cause;

    riscv_commit_checker #(
        .XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .state_o(state), .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt),
        .first_fail_v_o(ffv), .first_fail_idx_o(ffidx), .abort_cause_o(cause)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: table contents and the outcome of the current run.
    logic [2:0]  m_mode [NUM_CHECKS];
    logic [31:0] m_pc   [NUM_CHECKS];
    logic [31:0] m_a    [NUM_CHECKS];
    logic [31:0] m_d    [NUM_CHECKS];
    int m_pass, m_fail, m_ffidx, m_cause, m_state;
    bit m_ffv;
    logic [31:0] pc_set [6] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h80};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string p, input int st, input int ps, input int fl,
                                input int fv, input int fi, input int ca);
        check({p, ".state"}, 64'(state), 64'(st));
        check({p, ".pass"},  64'(pass_cnt), 64'(ps));
        check({p, ".fail"},  64'(fail_cnt), 64'(fl));
        check({p, ".ffv"},   64'(ffv), 64'(fv));
        if (fv != 0) check({p, ".ffidx"}, 64'(ffidx), 64'(fi));
        check({p, ".cause"}, 64'(cause), 64'(ca));
    endtask

    task automatic write_entry(input int idx, input logic [2:0] mode, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = IDX_W'(idx);
        bus.cfg_mode  = mode;
        bus.cfg_pc    = pc;
        bus.cfg_exp_a = a;
        bus.cfg_exp_d = d;
        m_mode[idx] = mode; m_pc[idx] = pc; m_a[idx] = a; m_d[idx] = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NUM_CHECKS; i++) write_entry(i, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] res,
                          input logic [31:0] adr = 32'h0, input logic [31:0] wd = 32'h0,
                          input logic mw = 1'b0);
        bus.ret_valid    = 1'b1;
        bus.ret_pc       = pc;
        bus.ret_result   = res;
        bus.ret_dataadr  = adr;
        bus.ret_wdata    = wd;
        bus.ret_memwrite = mw;
        tick();
        bus.ret_valid = 1'b0;
    endtask

    function automatic void m_begin();
        m_pass = 0; m_fail = 0; m_ffv = 1'b0; m_ffidx = 0; m_cause = 0; m_state = 1;
    endfunction

    // One retirement applied to the run: first matching entry decides, bound breach ends it.
    function automatic void m_retire(input logic [31:0] pc, input logic [31:0] res,
                                     input logic [31:0] adr, input logic [31:0] wd, input logic mw);
        int  hit;
        bit  ok;
        bit  counts;
        bit  viol;
        hit = -1; ok = 1'b0; counts = 1'b1; viol = 1'b0;
        if (m_state != 1) return;
        for (int i = 0; i < NUM_CHECKS; i++)
            if (hit < 0 && m_mode[i] >= 3'd1 && m_mode[i] <= 3'd4 && m_pc[i] == pc) hit = i;
        if (hit >= 0) begin
            case (m_mode[hit])
                3'd1: ok = (res == m_a[hit]);
                3'd2: ok = mw && (adr == m_a[hit]) && (wd == m_d[hit]);
                3'd3: ok = (adr == m_a[hit]) && (res == m_d[hit]);
                default: begin viol = (res > m_a[hit]); ok = !viol; counts = viol; end
            endcase
            if (counts) begin
                if (ok) m_pass = (m_pass < CNT_MAX) ? m_pass + 1 : CNT_MAX;
                else begin
                    m_fail = (m_fail < CNT_MAX) ? m_fail + 1 : CNT_MAX;
                    if (!m_ffv) begin m_ffv = 1'b1; m_ffidx = hit; end
                end
            end
        end
        if (viol) begin m_state = 3; m_cause = 1; end
        else if (pc == RAND_END) m_state = 2;
    endfunction

    initial begin
        logic [2:0]  md;
        logic [31:0] r_pc, r_res, r_adr, r_wd;
        logic        r_mw;
        int          nret;

        reset = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_mode = '0; bus.cfg_pc = '0;
        bus.cfg_exp_a = '0; bus.cfg_exp_d = '0; bus.end_pc = '0; bus.start = 1'b0;
        bus.ret_valid = 1'b0; bus.ret_pc = '0; bus.ret_result = '0; bus.ret_dataadr = '0;
        bus.ret_wdata = '0; bus.ret_memwrite = 1'b0;
        repeat (3) tick();
        check_status("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();

        // RES pass, then end_pc completes the run two edges after its retirement
        clear_table();
        write_entry(0, 3'd1, 32'h10, 32'd9, 32'd0);
        bus.end_pc = 32'h9C;
        pulse_start();
        check("t1.running", 64'(state), 64'd1);
        retire(32'h10, 32'd9);
        retire(32'h9C, 32'd0);
        check("t1.not_yet_done", 64'(state), 64'd1);
        tick();
        check_status("t1", 2, 1, 0, 0, 0, 0);

        // STORE with memwrite low fails; later matching store passes
        clear_table();
        write_entry(5, 3'd2, 32'h6C, 32'd40, 32'd16);
        pulse_start();
        retire(32'h6C, 32'd0, 32'd40, 32'd16, 1'b0);
        tick();
        check_status("t2a", 1, 0, 1, 1, 5, 0);
        retire(32'h6C, 32'd0, 32'd40, 32'd16, 1'b1);
        tick();
        check("t2b.pass", 64'(pass_cnt), 64'd1);
        retire(32'h9C, 32'd0);
        tick();
        check_status("t2c", 2, 1, 1, 1, 5, 0);

        // BOUND: 5 and 10 are within the limit, 11 aborts
        clear_table();
        write_entry(2, 3'd4, 32'h90, 32'd10, 32'd0);
        pulse_start();
        retire(32'h90, 32'd5);
        retire(32'h90, 32'd10);
        tick();
        check_status("t3a", 1, 0, 0, 0, 0, 0);
        retire(32'h90, 32'd11);
        tick();
        check_status("t3b", 3, 0, 1, 1, 2, 1);

        // end_pc coinciding with a bound breach aborts
        bus.end_pc = 32'h90;
        pulse_start();
        retire(32'h90, 32'd11);
        tick();
        check_status("t3c", 3, 0, 1, 1, 2, 1);
        bus.end_pc = 32'h9C;

        // Timeout with no retirements
        clear_table();
        pulse_start();
        repeat (TIMEOUT - 1) tick();
        check("t4.still_running", 64'(state), 64'd1);
        tick();
        check_status("t4", 3, 0, 0, 0, 0, 2);

        // Two entries on one PC: lower index decides
        clear_table();
        write_entry(3, 3'd1, 32'h34, 32'd1, 32'd0);
        write_entry(7, 3'd1, 32'h34, 32'd2, 32'd0);
        pulse_start();
        retire(32'h34, 32'd2);
        tick();
        check_status("t5", 1, 0, 1, 1, 3, 0);
        retire(32'h9C, 32'd0);
        tick();
        check("t5.done", 64'(state), 64'd2);

        // Pass counter saturates
        clear_table();
        write_entry(0, 3'd1, 32'h10, 32'd9, 32'd0);
        pulse_start();
        repeat (10) retire(32'h10, 32'd9);
        retire(32'h9C, 32'd0);
        tick();
        check_status("t7", 2, CNT_MAX, 0, 0, 0, 0);

        // Write in RUNNING ignored, then reset mid-run
        clear_table();
        write_entry(0, 3'd1, 32'h10, 32'd9, 32'd0);
        pulse_start();
        write_entry(0, 3'd1, 32'h10, 32'd1, 32'd0);
        retire(32'h10, 32'd1);
        retire(32'h10, 32'd1);
        tick();
        check_status("t6a", 1, 0, 2, 1, 0, 0);
        reset = 1'b0;
        tick();
        check_status("t6b", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        pulse_start();
        retire(32'h10, 32'd9);
        retire(32'h9C, 32'd0);
        tick();
        check_status("t6c", 2, 0, 0, 0, 0, 0);

        // Randomized runs against the model
        bus.end_pc = RAND_END;
        for (int run = 0; run < 40; run++) begin
            for (int e = 0; e < NUM_CHECKS; e++) begin
                md = 3'($urandom_range(0, 4));
                write_entry(e, md, pc_set[$urandom_range(0, 5)],
                            (md == 3'd2 || md == 3'd3) ? 32'h100 + 32'(4 * $urandom_range(0, 1))
                                                       : 32'($urandom_range(0, 3)),
                            32'($urandom_range(0, 3)));
            end
            pulse_start();
            m_begin();
            nret = $urandom_range(3, 8);
            for (int k = 0; k <= nret; k++) begin
                if (k < nret && $urandom_range(0, 4) == 0) begin
                    tick();
                end else begin
                    r_pc  = (k == nret) ? RAND_END
                          : (($urandom_range(0, 5) == 0) ? 32'h44 : pc_set[$urandom_range(0, 4)]);
                    r_res = ($urandom_range(0, 9) == 0) ? 32'd4 : 32'($urandom_range(0, 3));
                    r_adr = 32'h100 + 32'(4 * $urandom_range(0, 1));
                    r_wd  = 32'($urandom_range(0, 3));
                    r_mw  = 1'($urandom_range(0, 1));
                    retire(r_pc, r_res, r_adr, r_wd, r_mw);
                    m_retire(r_pc, r_res, r_adr, r_wd, r_mw);
                end
            end
            tick();
            tick();
            check("rand.state", 64'(state), 64'(m_state));
            check("rand.pass", 64'(pass_cnt), 64'(m_pass));
            check("rand.fail", 64'(fail_cnt), 64'(m_fail));
            check("rand.ffv", 64'(ffv), 64'(m_ffv));
            if (m_ffv) check("rand.ffidx", 64'(ffidx), 64'(m_ffidx));
            if (m_state == 3) check("rand.cause", 64'(cause), 64'(m_cause));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
